// File: rtl/fc_sweep_ctrl_pkg.sv
// Shared definitions for the carrier-frequency sweep controller and its carrier generator.
// Latency: n/a (constants, types and pure combinational helpers only).
// Backpressure: n/a.
package fc_sweep_ctrl_pkg;

  // Width of every frequency word (1 Hz units) and of the dwell counter (clk cycles).
  localparam int FC_W = 24;
  localparam int DW_W = 32;

  // Legal carrier range of the sine generator. FC_MIN is also the reset value of fc.
  localparam logic [FC_W-1:0] FC_MIN = 24'd1000;
  localparam logic [FC_W-1:0] FC_MAX = 24'd10_000_000;

  // Mode input encodings. Code 3 behaves as single.
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  typedef enum logic [1:0] {
    K_SINGLE,
    K_SAW,
    K_TRI
  } sweep_kind_t;

  // STEP is folded into the last DWELL cycle, so only two registered states exist.
  typedef enum logic {
    ST_IDLE,
    ST_DWELL
  } sweep_state_t;

  function automatic sweep_kind_t mode_to_kind(input logic [1:0] m);
    case (m)
      MODE_SAW: return K_SAW;
      MODE_TRI: return K_TRI;
      default:  return K_SINGLE;
    endcase
  endfunction

  function automatic logic [FC_W-1:0] fc_clamp(input logic [FC_W-1:0] x);
    if (x < FC_MIN) return FC_MIN;
    if (x > FC_MAX) return FC_MAX;
    return x;
  endfunction

  // One step from cur toward tgt; one extra bit catches both carry and borrow so the
  // result never wraps, and anything at or beyond the target is pinned to the target.
  function automatic logic [FC_W-1:0] fc_step_to(input logic [FC_W-1:0] cur,
                                                 input logic [FC_W-1:0] stp,
                                                 input logic [FC_W-1:0] tgt,
                                                 input logic            up);
    logic [FC_W:0] wide;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, stp};
      return (wide >= {1'b0, tgt}) ? tgt : wide[FC_W-1:0];
    end
    wide = {1'b0, cur} - {1'b0, stp};
    return (wide[FC_W] || (wide <= {1'b0, tgt})) ? tgt : wide[FC_W-1:0];
  endfunction

endpackage

// File: rtl/fc_dwell_timer.sv
// Dwell timer: holds each sweep frequency for a programmable number of cycles.
// Latency: expire is combinational from the count; asserted on the last cycle of each dwell.
// Backpressure: none; reloads itself on expire while run is high.
// Ports: clk, rst (sync active-low), load/load_val (start a new period, load_val >= 1),
//        run (count while high), expire (last cycle of the current dwell).
module fc_dwell_timer
  import fc_sweep_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DW_W-1:0] load_val,
  input  logic            run,
  output logic            expire
);

  logic [DW_W-1:0] period;
  logic [DW_W-1:0] cnt;

  assign expire = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      period <= DW_W'(1);
      cnt    <= '0;
    end else if (load) begin
      period <= load_val;
      cnt    <= load_val - DW_W'(1);
    end else if (expire) begin
      cnt <= period - DW_W'(1);
    end else if (run) begin
      cnt <= cnt - DW_W'(1);
    end
  end

endmodule

// File: rtl/fc_sweep_ctrl.sv
// Sweep controller: drives the carrier generator's fc word through single/sawtooth/triangle sweeps.
// Latency: fc=clamp(f_start) and busy one cycle after an accepted start; fc steps on the dwell-expire edge.
// Backpressure: none; start ignored while busy, abort wins over start and stops in one cycle.
// Ports: clk, rst (sync active-low), start, abort, mode, f_start, f_stop, f_step, dwell
//        -> fc (registered frequency word), busy, done (one-cycle pulse at end of a single sweep).
module fc_sweep_ctrl
  import fc_sweep_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic [FC_W-1:0] f_start,
  input  logic [FC_W-1:0] f_stop,
  input  logic [FC_W-1:0] f_step,
  input  logic [DW_W-1:0] dwell,
  output logic [FC_W-1:0] fc,
  output logic            busy,
  output logic            done
);

  sweep_state_t    state;
  sweep_kind_t     kind;
  logic [FC_W-1:0] start_q;
  logic [FC_W-1:0] stop_q;
  logic [FC_W-1:0] step_q;
  logic            up_q;     // start->stop direction, fixed for the sweep
  logic            leg_fwd;  // currently heading toward stop_q (triangle flips this)

  logic            accept;
  logic            expire;
  logic [DW_W-1:0] dwell_eff;
  logic [FC_W-1:0] cs;
  logic [FC_W-1:0] ce;
  logic [FC_W-1:0] leg_end;
  logic [FC_W-1:0] rev_end;
  logic            leg_up;
  logic            at_end;
  logic [FC_W-1:0] fwd_next;
  logic [FC_W-1:0] rev_next;

  assign accept    = (state == ST_IDLE) && start && !abort;
  assign dwell_eff = (dwell == '0) ? DW_W'(1) : dwell;
  assign cs        = fc_clamp(f_start);
  assign ce        = fc_clamp(f_stop);

  assign leg_end  = leg_fwd ? stop_q : start_q;
  assign rev_end  = leg_fwd ? start_q : stop_q;
  assign leg_up   = leg_fwd ? up_q : ~up_q;
  // A zero step can never reach the endpoint, so it is treated as already there:
  // single finishes after one dwell, the repeating modes simply hold.
  assign at_end   = (fc == leg_end) || (step_q == '0);
  assign fwd_next = fc_step_to(fc, step_q, leg_end, leg_up);
  // Triangle turnaround: the first value after the endpoint is already one step back.
  assign rev_next = fc_step_to(fc, step_q, rev_end, ~leg_up);

  fc_dwell_timer u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (dwell_eff),
    .run      (state == ST_DWELL),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      kind    <= K_SINGLE;
      fc      <= FC_MIN;
      busy    <= 1'b0;
      done    <= 1'b0;
      start_q <= FC_MIN;
      stop_q  <= FC_MIN;
      step_q  <= '0;
      up_q    <= 1'b1;
      leg_fwd <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            kind    <= mode_to_kind(mode);
            start_q <= cs;
            stop_q  <= ce;
            step_q  <= f_step;
            up_q    <= (ce >= cs);
            leg_fwd <= 1'b1;
            fc      <= cs;
            busy    <= 1'b1;
            state   <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (expire) begin
            if (!at_end) begin
              fc <= fwd_next;
            end else begin
              case (kind)
                K_SAW: fc <= start_q;
                K_TRI: begin
                  fc      <= rev_next;
                  leg_fwd <= ~leg_fwd;
                end
                default: begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end
              endcase
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
